// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Retire-trace recorder attached to the ROB commit ports. Valid commit lanes
//   are compacted into a circular buffer while ARMED. A trigger (external, or a
//   committed PC equal to trig_pc) starts a post-trigger window of POST_TRIGGER
//   records. After that window the buffer freezes. start_read then streams the
//   frozen window out oldest-first.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   commit_*              per-lane retire info, lane i at [i*W +: W]
//   arm / clear           start capture (IDLE only) / abort to IDLE
//   force_trig            external trigger
//   trig_pc_en, trig_pc   PC-match trigger
//   start_read            begin readout (FROZEN only)
//   rd_valid/rd_ready     readout handshake; rd_data, rd_last travel with it
//   state                 IDLE=0 ARMED=1 POST=2 FROZEN=3 READ=4 (debug view)
//   count                 valid records held
//   triggered             trigger seen since last arm
//
// Readout handshake: a record transfers on a rising edge where rd_valid and
// rd_ready are both high. rd_valid does not depend on rd_ready. rd_data and
// rd_last hold steady while rd_valid is high and rd_ready is low.
module retire_trace_buffer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int DEPTH        = 64,
  parameter int XLEN         = 32,
  parameter int PREG_BITS    = 6,
  parameter int TS_BITS      = 16,
  parameter int POST_TRIGGER = 16,
  parameter int REC_W        = TS_BITS + 1 + 5 + 2 * PREG_BITS + XLEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [COMMIT_WIDTH-1:0]           commit_valid,
  input  logic [COMMIT_WIDTH*XLEN-1:0]      commit_pc,
  input  logic [COMMIT_WIDTH-1:0]           commit_we,
  input  logic [COMMIT_WIDTH*5-1:0]         commit_rd_arch,
  input  logic [COMMIT_WIDTH*PREG_BITS-1:0] commit_rd_phy_new,
  input  logic [COMMIT_WIDTH*PREG_BITS-1:0] commit_rd_phy_old,
  input  logic                              arm,
  input  logic                              clear,
  input  logic                              force_trig,
  input  logic                              trig_pc_en,
  input  logic [XLEN-1:0]                   trig_pc,
  input  logic                              start_read,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [REC_W-1:0]                  rd_data,
  output logic                              rd_last,
  output logic [2:0]                        state,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              triggered
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_POST   = 3'd2;
  localparam logic [2:0] S_FROZEN = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;

  logic [REC_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   remaining;
  logic [TS_BITS-1:0] ts;

  logic                    capturing;
  logic                    pc_hit;
  logic                    trig;
  logic [COMMIT_WIDTH-1:0] lane_we;
  logic [PTR_W-1:0]        lane_slot [COMMIT_WIDTH];
  logic [REC_W-1:0]        lane_rec  [COMMIT_WIDTH];
  logic [CNT_W-1:0]        n_wr;
  logic [CNT_W-1:0]        count_sum;
  logic [CNT_W-1:0]        count_cap;

  assign capturing = !clear && (state == S_ARMED || state == S_POST);

  // Lane compaction. A running count of the lanes taken so far gives each
  // lane its slot offset from wr_ptr. In POST, only the lowest valid lanes
  // that still fit in the remaining budget are taken. Any other lanes are
  // dropped.
  always_comb begin
    lane_we = '0;
    n_wr    = '0;
    pc_hit  = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      lane_slot[i] = n_wr[PTR_W-1:0];
      lane_rec[i]  = {ts, commit_we[i], commit_rd_arch[i*5 +: 5],
                      commit_rd_phy_new[i*PREG_BITS +: PREG_BITS],
                      commit_rd_phy_old[i*PREG_BITS +: PREG_BITS],
                      commit_pc[i*XLEN +: XLEN]};
      if (commit_valid[i] && commit_pc[i*XLEN +: XLEN] == trig_pc)
        pc_hit = 1'b1;
      if (capturing && commit_valid[i] && (state == S_ARMED || n_wr < remaining)) begin
        lane_we[i] = 1'b1;
        n_wr       = n_wr + CNT_W'(1);
      end
    end
  end

  assign trig      = force_trig || (trig_pc_en && pc_hit);
  assign count_sum = count + n_wr;
  // Once the buffer is full, new records overwrite the oldest. count stays
  // pinned at DEPTH.
  assign count_cap = (count_sum > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count_sum;

  // Storage is not reset. Nothing reads it outside READ, and a READ window
  // only covers slots that were written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (lane_we[i])
        mem[wr_ptr + lane_slot[i]] <= lane_rec[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      remaining <= '0;
      triggered <= 1'b0;
      ts        <= '0;
    end else begin
      ts <= ts + TS_BITS'(1);
      if (clear) begin
        state     <= S_IDLE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        remaining <= '0;
        triggered <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              state     <= S_ARMED;
              wr_ptr    <= '0;
              rd_ptr    <= '0;
              count     <= '0;
              triggered <= 1'b0;
            end
          end
          S_ARMED: begin
            wr_ptr <= wr_ptr + n_wr[PTR_W-1:0];
            count  <= count_cap;
            // The records of the trigger cycle itself do not use any of the
            // post-trigger budget.
            if (trig) begin
              state     <= S_POST;
              remaining <= CNT_W'(POST_TRIGGER);
              triggered <= 1'b1;
            end
          end
          S_POST: begin
            wr_ptr    <= wr_ptr + n_wr[PTR_W-1:0];
            count     <= count_cap;
            remaining <= remaining - n_wr;
            // This also covers a budget that starts at zero: no writes, and
            // the buffer freezes.
            if (remaining == n_wr)
              state <= S_FROZEN;
          end
          S_FROZEN: begin
            if (start_read) begin
              if (count == '0) begin
                state <= S_IDLE;
              end else begin
                state  <= S_READ;
                rd_ptr <= wr_ptr - count[PTR_W-1:0];
              end
            end
          end
          S_READ: begin
            if (rd_ready) begin
              rd_ptr <= rd_ptr + PTR_W'(1);
              count  <= count - CNT_W'(1);
              if (count == CNT_W'(1))
                state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_valid = (state == S_READ);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign rd_last  = rd_valid && (count == CNT_W'(1));

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer. The bench uses two instances:
// dut (DEPTH=8, POST_TRIGGER=2) and dut0 (DEPTH=8, POST_TRIGGER=0). Both
// instances share the same stimulus. sel picks the instance that the readout
// helper observes. Expected records are built from the driven commit fields
// and a bench-side timestamp counter.
module tb_retire_trace_buffer;

  localparam int CW    = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int PB    = 6;
  localparam int TSB   = 16;
  localparam int REC_W = TSB + 1 + 5 + 2 * PB + XLEN;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CW-1:0]      commit_valid;
  logic [CW*XLEN-1:0] commit_pc;
  logic [CW-1:0]      commit_we;
  logic [CW*5-1:0]    commit_rd_arch;
  logic [CW*PB-1:0]   commit_rd_phy_new;
  logic [CW*PB-1:0]   commit_rd_phy_old;
  logic               arm, clear, force_trig, trig_pc_en, start_read, rd_ready;
  logic [XLEN-1:0]    trig_pc;

  logic               d_valid, d_last, d_trig;
  logic [REC_W-1:0]   d_data;
  logic [2:0]         d_state;
  logic [CNT_W-1:0]   d_count;
  logic               z_valid, z_last, z_trig;
  logic [REC_W-1:0]   z_data;
  logic [2:0]         z_state;
  logic [CNT_W-1:0]   z_count;

  retire_trace_buffer #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH), .XLEN(XLEN), .PREG_BITS(PB),
                        .TS_BITS(TSB), .POST_TRIGGER(2)) dut (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_we(commit_we), .commit_rd_arch(commit_rd_arch),
    .commit_rd_phy_new(commit_rd_phy_new), .commit_rd_phy_old(commit_rd_phy_old),
    .arm(arm), .clear(clear), .force_trig(force_trig), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .start_read(start_read), .rd_valid(d_valid), .rd_ready(rd_ready),
    .rd_data(d_data), .rd_last(d_last), .state(d_state), .count(d_count),
    .triggered(d_trig));

  retire_trace_buffer #(.COMMIT_WIDTH(CW), .DEPTH(DEPTH), .XLEN(XLEN), .PREG_BITS(PB),
                        .TS_BITS(TSB), .POST_TRIGGER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_we(commit_we), .commit_rd_arch(commit_rd_arch),
    .commit_rd_phy_new(commit_rd_phy_new), .commit_rd_phy_old(commit_rd_phy_old),
    .arm(arm), .clear(clear), .force_trig(force_trig), .trig_pc_en(trig_pc_en),
    .trig_pc(trig_pc), .start_read(start_read), .rd_valid(z_valid), .rd_ready(rd_ready),
    .rd_data(z_data), .rd_last(z_last), .state(z_state), .count(z_count),
    .triggered(z_trig));

  logic sel;
  wire              obs_valid = sel ? z_valid : d_valid;
  wire              obs_last  = sel ? z_last  : d_last;
  wire [REC_W-1:0]  obs_data  = sel ? z_data  : d_data;
  wire [2:0]        obs_state = sel ? z_state : d_state;
  wire [CNT_W-1:0]  obs_count = sel ? z_count : d_count;
  wire              obs_trig  = sel ? z_trig  : d_trig;

  // Bench timestamp model: a free-running cycle counter that clears on reset.
  logic [TSB-1:0] tb_ts;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;

  // scoreboard
  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] make_rec(input logic [TSB-1:0] t, input logic [31:0] pc);
    return {t, pc[2], pc[6:2], pc[7:2], pc[9:4], pc};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  // Drive one commit cycle. keep marks the lanes that are expected to land in
  // the buffer. Kept lanes are pushed in lane order, which matches compaction.
  task automatic commit2(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] keep);
    commit_valid      = v;
    commit_pc         = {pc1, pc0};
    commit_we         = {pc1[2], pc0[2]};
    commit_rd_arch    = {pc1[6:2], pc0[6:2]};
    commit_rd_phy_new = {pc1[7:2], pc0[7:2]};
    commit_rd_phy_old = {pc1[9:4], pc0[9:4]};
    if (keep[0]) exp_q.push_back(make_rec(tb_ts, pc0));
    if (keep[1]) exp_q.push_back(make_rec(tb_ts, pc1));
    tick();
    commit_valid = '0;
    force_trig   = 1'b0;
  endtask

  // Stream out the frozen window from the selected instance. When bp is set,
  // rd_ready follows the pattern 1,0,0,1.
  task automatic read_window(input bit bp);
    int k;
    logic go;
    logic [TSB-1:0] prev_ts;
    while (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    start_read = 1'b1; tick(); start_read = 1'b0;
    check_eq("read_state", obs_state, 3'd4);
    k = 0;
    prev_ts = '0;
    while (exp_q.size() > 0 && k < 64) begin
      check_eq("rd_valid", obs_valid, 1'b1);
      go = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      if (obs_valid) begin
        check_eq("rd_data", obs_data, exp_q[0]);
        check_eq("rd_last", obs_last, exp_q.size() == 1);
        if (go) begin
          check_eq("ts_order", obs_data[REC_W-1 -: TSB] >= prev_ts, 1'b1);
          prev_ts = obs_data[REC_W-1 -: TSB];
          void'(exp_q.pop_front());
        end
      end
      rd_ready = go;
      tick();
      k++;
    end
    rd_ready = 1'b0;
    check_eq("read_done", exp_q.size(), 0);
    check_eq("idle_after_read", obs_state, 3'd0);
    check_eq("rd_valid_after", obs_valid, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    commit_valid = '0; commit_pc = '0; commit_we = '0; commit_rd_arch = '0;
    commit_rd_phy_new = '0; commit_rd_phy_old = '0;
    arm = 1'b0; clear = 1'b0; force_trig = 1'b0; trig_pc_en = 1'b0; trig_pc = '0;
    start_read = 1'b0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_state", d_state, 3'd0);
    check_eq("rst_count", d_count, 0);
    check_eq("rst_trig", d_trig, 1'b0);
    check_eq("rst_rd_valid", d_valid, 1'b0);
    check_eq("rst_rd_last", d_last, 1'b0);
    check_eq("rst_rd_data", d_data, 0);
    check_eq("rst_state0", z_state, 3'd0);
    rst_n = 1'b1;
    tick();

    // Single commits with force_trig at 0x10C. The window is 0x100..0x114.
    pulse_arm();
    check_eq("t1_armed", d_state, 3'd1);
    commit2(2'b01, 32'h100, 32'h0, 2'b01);
    commit2(2'b01, 32'h104, 32'h0, 2'b01);
    commit2(2'b01, 32'h108, 32'h0, 2'b01);
    force_trig = 1'b1;
    commit2(2'b01, 32'h10C, 32'h0, 2'b01);
    check_eq("t1_post", d_state, 3'd2);
    check_eq("t1_triggered", d_trig, 1'b1);
    check_eq("t1_count_trig", d_count, 4);
    commit2(2'b01, 32'h110, 32'h0, 2'b01);
    commit2(2'b01, 32'h114, 32'h0, 2'b01);
    check_eq("t1_frozen", d_state, 3'd3);
    check_eq("t1_count", d_count, 6);
    commit2(2'b01, 32'h118, 32'h0, 2'b00);
    commit2(2'b01, 32'h11C, 32'h0, 2'b00);
    check_eq("t1_count_hold", d_count, 6);
    read_window(1'b0);

    // Dual commits with the PC trigger at 0x150. The buffer saturates at 8.
    exp_q.delete();
    trig_pc_en = 1'b1; trig_pc = 32'h150;
    pulse_arm();
    for (int k = 0; k < 14; k++) begin
      commit2(2'b11, 32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k), (k < 12) ? 2'b11 : 2'b00);
      if (k == 10) check_eq("t2_post", d_state, 3'd2);
      if (k == 11) check_eq("t2_frozen", d_state, 3'd3);
    end
    check_eq("t2_count_sat", d_count, 8);
    trig_pc_en = 1'b0;
    read_window(1'b0);

    // Lane compaction and budget truncation in POST, read with backpressure.
    exp_q.delete();
    pulse_arm();
    commit2(2'b10, 32'h1F0, 32'h200, 2'b10);
    check_eq("t3_count1", d_count, 1);
    commit2(2'b11, 32'h210, 32'h214, 2'b11);
    force_trig = 1'b1;
    commit2(2'b01, 32'h220, 32'h0, 2'b01);
    check_eq("t3_count_trig", d_count, 4);
    commit2(2'b10, 32'h230, 32'h234, 2'b10);
    check_eq("t3_still_post", d_state, 3'd2);
    commit2(2'b11, 32'h240, 32'h244, 2'b01);
    check_eq("t3_frozen", d_state, 3'd3);
    check_eq("t3_count", d_count, 6);
    read_window(1'b1);

    // POST_TRIGGER=0 instance.
    pulse_clear();
    sel = 1'b1;
    exp_q.delete();
    pulse_arm();
    force_trig = 1'b1;
    commit2(2'b11, 32'h300, 32'h304, 2'b11);
    check_eq("t4_post", obs_state, 3'd2);
    check_eq("t4_count_trig", obs_count, 2);
    check_eq("t4_triggered", obs_trig, 1'b1);
    commit2(2'b11, 32'h308, 32'h30C, 2'b00);
    check_eq("t4_frozen", obs_state, 3'd3);
    commit2(2'b01, 32'h310, 32'h0, 2'b00);
    check_eq("t4_count_hold", obs_count, 2);
    read_window(1'b0);
    // Arm is ignored by dut, because dut is still mid-readout.
    pulse_arm();
    check_eq("t4_arm_ignored", d_state, 3'd4);
    check_eq("t4_arm_ignored_cnt", d_count, 2);
    force_trig = 1'b1;
    commit2(2'b00, 32'h0, 32'h0, 2'b00);
    check_eq("t4_empty_post", obs_state, 3'd2);
    tick();
    check_eq("t4_empty_frozen", obs_state, 3'd3);
    check_eq("t4_empty_count", obs_count, 0);
    start_read = 1'b1; tick(); start_read = 1'b0;
    check_eq("t4_empty_idle", obs_state, 3'd0);
    check_eq("t4_empty_no_valid", obs_valid, 1'b0);

    // Clear during POST.
    pulse_clear();
    sel = 1'b0;
    exp_q.delete();
    pulse_arm();
    force_trig = 1'b1;
    commit2(2'b01, 32'h400, 32'h0, 2'b01);
    check_eq("t5_post", d_state, 3'd2);
    pulse_clear();
    check_eq("t5_state", d_state, 3'd0);
    check_eq("t5_count", d_count, 0);
    check_eq("t5_trig", d_trig, 1'b0);
    check_eq("t5_rd_valid", d_valid, 1'b0);

    // Asynchronous reset during READ.
    exp_q.delete();
    pulse_arm();
    force_trig = 1'b1;
    commit2(2'b11, 32'h500, 32'h504, 2'b11);
    commit2(2'b11, 32'h508, 32'h50C, 2'b11);
    check_eq("t6_frozen", d_state, 3'd3);
    check_eq("t6_count", d_count, 4);
    start_read = 1'b1; tick(); start_read = 1'b0;
    check_eq("t6_read", d_state, 3'd4);
    check_eq("t6_first", d_data, exp_q[0]);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_state", d_state, 3'd0);
    check_eq("t6_rst_count", d_count, 0);
    check_eq("t6_rst_trig", d_trig, 1'b0);
    check_eq("t6_rst_valid", d_valid, 1'b0);
    check_eq("t6_rst_data", d_data, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_after_state", d_state, 3'd0);
    check_eq("t6_after_valid", d_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
